// File: rtl/hamming74_pkg.sv
// Hamming(7,4) shared widths plus encode and syndrome helpers.
// Codeword bit n-1 holds Hamming position n: {d3,d2,d1,p4,d0,p2,p1}.
package hamming74_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned CODE_W = 7;
    localparam int unsigned SYN_W  = 3;

    function automatic logic [CODE_W-1:0] ham74_encode(input logic [DATA_W-1:0] d);
        logic p1;
        logic p2;
        logic p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    // Syndrome value is the 1-based position of a single flipped bit.
    function automatic logic [SYN_W-1:0] ham74_syndrome(input logic [CODE_W-1:0] c);
        logic s1;
        logic s2;
        logic s4;
        s1 = c[0] ^ c[2] ^ c[4] ^ c[6];
        s2 = c[1] ^ c[2] ^ c[5] ^ c[6];
        s4 = c[3] ^ c[4] ^ c[5] ^ c[6];
        return {s4, s2, s1};
    endfunction

endpackage

// File: rtl/hamming74_dec.sv
// Combinational Hamming(7,4) decoder: corrects any single-bit error.
// Double-bit errors are miscorrected; no detection is attempted.
module hamming74_dec
    import hamming74_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [DATA_W-1:0] data,
    output logic [SYN_W-1:0]  syndrome,
    output logic              err
);

    logic [SYN_W-1:0]  syn_c;
    logic [CODE_W-1:0] flip_c;
    logic [CODE_W-1:0] corrected_c;

    always_comb begin
        syn_c       = ham74_syndrome(code);
        flip_c      = '0;
        if (syn_c != '0) begin
            flip_c = CODE_W'(1) << (syn_c - SYN_W'(1));
        end
        corrected_c = code ^ flip_c;
    end

    assign data     = {corrected_c[6], corrected_c[5], corrected_c[4], corrected_c[2]};
    assign syndrome = syn_c;
    assign err      = |syn_c;

endmodule

// File: rtl/dedee_hamming74.sv
// Hamming(7,4) loopback: registered encoder feeding the decoder, with an
// optional decoder output register selected by DEC_REG.
module dedee_hamming74
    import hamming74_pkg::*;
#(
    parameter bit DEC_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    output logic [CODE_W-1:0] encoded_data,
    output logic [DATA_W-1:0] data_out,
    output logic [SYN_W-1:0]  syndrome,
    output logic              error_flag
);

    logic [CODE_W-1:0] encoded_q;
    logic [CODE_W-1:0] encoded_d;
    logic [DATA_W-1:0] dec_data;
    logic [SYN_W-1:0]  dec_syn;
    logic              dec_err;

    assign encoded_d = ham74_encode(data_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            encoded_q <= '0;
        end else begin
            encoded_q <= encoded_d;
        end
    end

    assign encoded_data = encoded_q;

    hamming74_dec u_dec (
        .code     (encoded_q),
        .data     (dec_data),
        .syndrome (dec_syn),
        .err      (dec_err)
    );

    if (DEC_REG) begin : g_dec_reg
        logic [DATA_W-1:0] data_q;
        logic [SYN_W-1:0]  syn_q;
        logic              err_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q <= '0;
                syn_q  <= '0;
                err_q  <= 1'b0;
            end else begin
                data_q <= dec_data;
                syn_q  <= dec_syn;
                err_q  <= dec_err;
            end
        end

        assign data_out   = data_q;
        assign syndrome   = syn_q;
        assign error_flag = err_q;
    end else begin : g_dec_comb
        assign data_out   = dec_data;
        assign syndrome   = dec_syn;
        assign error_flag = dec_err;
    end

endmodule

// File: tb/tb_dedee_hamming74.sv
// Bench for dedee_hamming74 (both DEC_REG builds) and the standalone decoder,
// against a position-based Hamming reference model.
module tb_dedee_hamming74;

    logic       clk;
    logic       rst;
    logic [3:0] data_in;

    logic [6:0] enc1, enc0;
    logic [3:0] dout1, dout0;
    logic [2:0] syn1, syn0;
    logic       err1, err0;

    logic [6:0] code_t;
    logic [3:0] ddata;
    logic [2:0] dsyn;
    logic       derr;

    int n_cmp = 0;
    int n_mis = 0;

    logic [3:0] cur_d  = '0;
    logic [3:0] prev_d = '0;

    dedee_hamming74 #(.DEC_REG(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .data_in(data_in),
        .encoded_data(enc1), .data_out(dout1), .syndrome(syn1), .error_flag(err1)
    );

    dedee_hamming74 #(.DEC_REG(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .data_in(data_in),
        .encoded_data(enc0), .data_out(dout0), .syndrome(syn0), .error_flag(err0)
    );

    hamming74_dec u_dec (
        .code(code_t), .data(ddata), .syndrome(dsyn), .err(derr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: place data at positions 3,5,6,7; parity p covers every position n with n&p.
    function automatic logic [6:0] ref_enc(input logic [3:0] d);
        int dpos[4] = '{3, 5, 6, 7};
        logic [7:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) w[dpos[i]] = d[i];
        for (int p = 1; p <= 4; p = p * 2) begin
            logic par;
            par = 1'b0;
            for (int n = 1; n <= 7; n++)
                if (((n & p) != 0) && (n != p)) par = par ^ w[n];
            w[p] = par;
        end
        return w[7:1];
    endfunction

    // Syndrome is the XOR of the positions of all set bits.
    function automatic int ref_syn(input logic [6:0] c);
        int s;
        s = 0;
        for (int n = 1; n <= 7; n++) if (c[n-1]) s = s ^ n;
        return s;
    endfunction

    function automatic logic [3:0] ref_dec(input logic [6:0] c);
        logic [7:0] w;
        int s;
        w = {c, 1'b0};
        s = ref_syn(c);
        if (s != 0) w[s] = ~w[s];
        return {w[7], w[6], w[5], w[3]};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one nibble, advance one edge, check both builds against the model.
    task automatic step(input logic [3:0] d);
        data_in = d;
        @(posedge clk);
        #1;
        prev_d = cur_d;
        cur_d  = d;
        chk("enc1",  8'(enc1),  8'(ref_enc(cur_d)));
        chk("dout1", 8'(dout1), 8'(prev_d));
        chk("syn1",  8'(syn1),  8'h0);
        chk("err1",  8'(err1),  8'h0);
        chk("enc0",  8'(enc0),  8'(ref_enc(cur_d)));
        chk("dout0", 8'(dout0), 8'(cur_d));
        chk("syn0",  8'(syn0),  8'h0);
        chk("err0",  8'(err0),  8'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        cur_d  = '0;
        prev_d = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_enc1"}, 8'(enc1), 8'h0);
        chk({tag, "_dout1"}, 8'(dout1), 8'h0);
        chk({tag, "_syn1"}, 8'(syn1), 8'h0);
        chk({tag, "_err1"}, 8'(err1), 8'h0);
        chk({tag, "_enc0"}, 8'(enc0), 8'h0);
        chk({tag, "_dout0"}, 8'(dout0), 8'h0);
    endtask

    logic [3:0] sweep_d[6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0101, 4'b1010, 4'b1111};
    logic [6:0] sweep_c[6] = '{7'b0000000, 7'b0000111, 7'b0011001,
                               7'b0101101, 7'b1010010, 7'b1111111};
    logic [3:0] loop_d[8]  = '{4'b0000, 4'b0001, 4'b0010, 4'b0101,
                               4'b1010, 4'b1111, 4'b1001, 4'b0110};

    initial begin
        rst     = 1'b1;
        data_in = 4'b0000;
        code_t  = '0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // DEC_REG=0: first edge after reset shows codeword and decoded data together.
        step(4'b1001);
        chk("first_enc0",  8'(enc0),  8'(7'b1001100));
        chk("first_dout0", 8'(dout0), 8'(4'b1001));

        for (int i = 0; i < 6; i++) begin
            step(sweep_d[i]);
            chk("sweep_enc", 8'(enc1), 8'(sweep_c[i]));
        end

        for (int i = 0; i < 8; i++) step(loop_d[i]);
        step(4'b0000);
        chk("loop_tail", 8'(dout1), 8'(4'b0110));

        // Asynchronous reset mid-cycle with data held at 1111.
        step(4'b1111);
        step(4'b1111);
        #3;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        rst    = 1'b0;
        cur_d  = '0;
        prev_d = '0;

        repeat (200) step(4'($urandom_range(0, 15)));

        do_reset();
        step(4'b1001);
        chk("rst2_enc0",  8'(enc0),  8'(7'b1001100));
        chk("rst2_dout0", 8'(dout0), 8'(4'b1001));
        chk("rst2_dout1", 8'(dout1), 8'h0);

        // Standalone decoder: clean codewords and every single-bit error.
        for (int d = 0; d < 16; d++) begin
            logic [6:0] cw;
            cw = ref_enc(4'(d));
            code_t = cw;
            #1;
            chk("dec_clean_syn",  8'(dsyn),  8'h0);
            chk("dec_clean_err",  8'(derr),  8'h0);
            chk("dec_clean_data", 8'(ddata), 8'(d));
            for (int k = 0; k < 7; k++) begin
                logic [6:0] flip;
                flip = 7'(1) << k;
                code_t = cw ^ flip;
                #1;
                chk("dec_err_syn",  8'(dsyn),  8'(k + 1));
                chk("dec_err_flag", 8'(derr),  8'h1);
                chk("dec_err_data", 8'(ddata), 8'(d));
                chk("dec_err_ref",  8'(ddata), 8'(ref_dec(cw ^ flip)));
            end
        end

        code_t = 7'b0101101;
        #1;
        chk("dec_0101_clean", 8'(ddata), 8'(4'b0101));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
